// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg
//   Shared definitions for the operand loader and the controller that drives it.
//   - loader_state_t : loader FSM states.
//   - TGT_LEFT/TGT_TOP : buffer target encoding. The controller's LOAD_LEFT /
//     LOAD_TOP instruction decode uses the same constants.
package operand_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    SWAP,
    DONE
  } loader_state_t;

  localparam logic TGT_LEFT = 1'b0;
  localparam logic TGT_TOP  = 1'b1;

endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if
//   Bundles the three buses the loader touches:
//   - controller request: start / target_top / swap_after / base_addr / abort,
//     with status busy / done back to the controller;
//   - scratchpad port B: rd_addr out, rd_data in (1-cycle synchronous read);
//   - systolic array buffer load ports, left and top.
//   modport slave  : the loader itself.
//   modport master : the environment (controller + scratchpad + buffers).
interface operand_loader_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int DP_ADDR_WIDTH = 10,
  parameter int MATRIX_SIZE   = 8,
  parameter int ADDR_WIDTH    = $clog2(MATRIX_SIZE)
);
  logic                     start;
  logic                     target_top;
  logic                     swap_after;
  logic [DP_ADDR_WIDTH-1:0] base_addr;
  logic                     abort;
  logic [DP_ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     load_en_left;
  logic                     load_en_top;
  logic [ADDR_WIDTH-1:0]    addr_left;
  logic [ADDR_WIDTH-1:0]    addr_top;
  logic [DATA_WIDTH-1:0]    data_in_left;
  logic [DATA_WIDTH-1:0]    data_in_top;
  logic                     swap_buffers_left;
  logic                     swap_buffers_top;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, target_top, swap_after, base_addr, abort, rd_data,
    output rd_addr, load_en_left, load_en_top, addr_left, addr_top,
           data_in_left, data_in_top, swap_buffers_left, swap_buffers_top,
           busy, done
  );

  modport master (
    output start, target_top, swap_after, base_addr, abort, rd_data,
    input  rd_addr, load_en_left, load_en_top, addr_left, addr_top,
           data_in_left, data_in_top, swap_buffers_left, swap_buffers_top,
           busy, done
  );
endinterface

// File: rtl/operand_loader.sv
// operand_loader
//   Streams one MATRIX_SIZE-element operand vector from scratchpad port B into
//   the left or top input buffer of the systolic array, then optionally pulses
//   that buffer's swap, then pulses done.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : operand_loader_if.slave
//          start/target_top/swap_after/base_addr sampled on an IDLE start,
//          abort cancels at the next edge (beats start and every transition),
//          rd_addr registered scratchpad address, rd_data 1-cycle read data,
//          load_en/addr/data_in/swap_buffers per buffer, busy, done.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_SIZE   = 8,
  parameter int DP_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH    = $clog2(MATRIX_SIZE)
) (
  input logic              clk,
  input logic              rst,
  operand_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(MATRIX_SIZE + 1);
  localparam logic [CNT_W-1:0]      LAST_ISSUE = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_LOAD  = ADDR_WIDTH'(MATRIX_SIZE - 1);

  loader_state_t            state, nxt;
  logic                     tgt_q;
  logic                     swap_q;
  logic [DP_ADDR_WIDTH-1:0] rd_addr_q;
  logic [CNT_W-1:0]         issue_cnt;
  logic [ADDR_WIDTH-1:0]    load_cnt;
  // vld_pipe[0]: an address is on rd_addr this cycle
  // vld_pipe[1]: its read data is on rd_data this cycle (rd_valid)
  logic [1:0]               vld_pipe;
  logic                     rd_valid;
  logic                     accept;
  logic                     issue_now;

  assign rd_valid  = vld_pipe[1];
  assign accept    = (state == IDLE) && bus.start && !bus.abort;
  assign issue_now = accept || ((state == READ) && !bus.abort);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = READ;
      // issue_cnt counts addresses already issued; this edge issues the last
      READ:    if (issue_cnt == LAST_ISSUE) nxt = DRAIN;
      DRAIN:   if (rd_valid && (load_cnt == LAST_LOAD)) nxt = swap_q ? SWAP : DONE;
      SWAP:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.abort) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tgt_q     <= TGT_LEFT;
      swap_q    <= 1'b0;
      rd_addr_q <= '0;
      issue_cnt <= '0;
      load_cnt  <= '0;
      vld_pipe  <= '0;
    end else begin
      state <= nxt;
      // abort drops any read still in flight so no strobe follows it
      vld_pipe <= bus.abort ? 2'b00 : {vld_pipe[0], issue_now};
      if (accept) begin
        tgt_q     <= bus.target_top;
        swap_q    <= bus.swap_after;
        rd_addr_q <= bus.base_addr;
        issue_cnt <= CNT_W'(1);
      end else if ((state == READ) && !bus.abort) begin
        rd_addr_q <= rd_addr_q + DP_ADDR_WIDTH'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (accept)        load_cnt <= '0;
      else if (rd_valid) load_cnt <= load_cnt + ADDR_WIDTH'(1);
    end
  end

  assign bus.rd_addr = rd_addr_q;

  // Strobes are decoded straight from registers, so reset clears them
  // immediately and they never glitch.
  assign bus.load_en_left = rd_valid && (tgt_q == TGT_LEFT);
  assign bus.load_en_top  = rd_valid && (tgt_q == TGT_TOP);
  assign bus.addr_left    = bus.load_en_left ? load_cnt : '0;
  assign bus.addr_top     = bus.load_en_top  ? load_cnt : '0;
  assign bus.data_in_left = bus.load_en_left ? bus.rd_data : '0;
  assign bus.data_in_top  = bus.load_en_top  ? bus.rd_data : '0;

  assign bus.swap_buffers_left = (state == SWAP) && (tgt_q == TGT_LEFT);
  assign bus.swap_buffers_top  = (state == SWAP) && (tgt_q == TGT_TOP);
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader
//   Drives loads into operand_loader with a scratchpad model and compares
//   every observed cycle against a per-cycle expectation derived from the
//   load rules (strobe i in cycle i+1 after the start edge, swap, done).
module tb_operand_loader;
  localparam int DW = 8;
  localparam int N  = 8;
  localparam int AW = 10;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_loader_if #(.DATA_WIDTH(DW), .DP_ADDR_WIDTH(AW), .MATRIX_SIZE(N)) bus ();

  operand_loader #(.DATA_WIDTH(DW), .MATRIX_SIZE(N), .DP_ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [1024];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  typedef struct packed {
    logic          en_l, en_t;
    logic [IW-1:0] a_l, a_t;
    logic [DW-1:0] d_l, d_t;
    logic          sw_l, sw_t, done, busy;
    logic [AW-1:0] ra;
  } obs_t;

  obs_t trace[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t sample();
    obs_t o;
    o.en_l = bus.load_en_left;      o.en_t = bus.load_en_top;
    o.a_l  = bus.addr_left;         o.a_t  = bus.addr_top;
    o.d_l  = bus.data_in_left;      o.d_t  = bus.data_in_top;
    o.sw_l = bus.swap_buffers_left; o.sw_t = bus.swap_buffers_top;
    o.done = bus.done;              o.busy = bus.busy;
    o.ra   = bus.rd_addr;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("en=%b%b a=%0d/%0d d=%h/%h sw=%b%b done=%b busy=%b ra=%0d",
                     o.en_l, o.en_t, o.a_l, o.a_t, o.d_l, o.d_t,
                     o.sw_l, o.sw_t, o.done, o.busy, o.ra);
  endfunction

  // Expected outputs in the cycle after edge E(c), E0 being the start edge.
  // abort_cyc < 0: no abort; otherwise abort is held in cycle abort_cyc.
  function automatic obs_t model(input logic [AW-1:0] base, input bit top,
                                 input bit swp, input int abort_cyc, input int c);
    obs_t o = '0;
    int   d = N + 1 + (swp ? 1 : 0);
    bit   live = (abort_cyc < 0) || (c <= abort_cyc);
    int   steps = c;
    logic [AW-1:0] wa;
    if (steps > N - 1) steps = N - 1;
    if (abort_cyc >= 0 && steps > abort_cyc) steps = abort_cyc;
    o.ra = base + AW'(steps);
    if (live && c >= 1 && c <= N) begin
      wa = base + AW'(c - 1);
      if (top) begin o.en_t = 1'b1; o.a_t = IW'(c - 1); o.d_t = mem[wa]; end
      else     begin o.en_l = 1'b1; o.a_l = IW'(c - 1); o.d_l = mem[wa]; end
    end
    if (live && swp && c == N + 1) begin
      if (top) o.sw_t = 1'b1; else o.sw_l = 1'b1;
    end
    o.done = live && (c == d);
    o.busy = live && (c <= d);
    return o;
  endfunction

  // Pulses start, then records ncyc cycles. Optionally asserts abort in one
  // cycle, or re-pulses start (different base/target) while busy.
  task automatic run_load(input logic [AW-1:0] base, input bit top, input bit swp,
                          input int abort_cyc, input int restart_cyc, input int ncyc);
    trace.delete();
    @(negedge clk);
    bus.start = 1'b1; bus.target_top = top; bus.swap_after = swp; bus.base_addr = base;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      trace.push_back(sample());
      bus.start = 1'b0;
      bus.abort = (c == abort_cyc);
      if (c == restart_cyc) begin
        bus.start = 1'b1; bus.base_addr = AW'(500);
        bus.target_top = ~top; bus.swap_after = ~swp;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    o = sample();
    n_cmp++;
    if (o !== '0) begin
      n_bad++; $display("FAIL reset_state got %s exp all zero", fmt(o));
    end
  endtask

  task automatic test_left_basic();
    obs_t e;
    for (int i = 0; i < N; i++) mem[16 + i] = DW'(i + 1);
    run_load(AW'(16), 1'b0, 1'b0, -1, -1, N + 5);
    for (int c = 0; c < trace.size(); c++) begin
      e = model(AW'(16), 1'b0, 1'b0, -1, c);
      n_cmp++;
      if (trace[c] !== e) begin
        n_bad++; $display("FAIL left_basic c%0d got %s exp %s", c, fmt(trace[c]), fmt(e));
      end
    end
  endtask

  task automatic test_top_swap();
    obs_t e;
    run_load(AW'(16), 1'b1, 1'b1, -1, -1, N + 5);
    for (int c = 0; c < trace.size(); c++) begin
      e = model(AW'(16), 1'b1, 1'b1, -1, c);
      n_cmp++;
      if (trace[c] !== e) begin
        n_bad++; $display("FAIL top_swap c%0d got %s exp %s", c, fmt(trace[c]), fmt(e));
      end
    end
  endtask

  task automatic test_addr_wrap();
    obs_t e;
    for (int c = 0; c < trace.size() + 1; c++) ;
    run_load(AW'(1020), 1'b0, 1'b1, -1, -1, N + 5);
    for (int c = 0; c < trace.size(); c++) begin
      e = model(AW'(1020), 1'b0, 1'b1, -1, c);
      n_cmp++;
      if (trace[c] !== e) begin
        n_bad++; $display("FAIL addr_wrap c%0d got %s exp %s", c, fmt(trace[c]), fmt(e));
      end
    end
    // explicit wrapped address sequence
    for (int c = 4; c < N; c++) begin
      n_cmp++;
      if (trace[c].ra !== AW'(c - 4)) begin
        n_bad++; $display("FAIL wrap_rd_addr c%0d got %0d exp %0d", c, trace[c].ra, c - 4);
      end
    end
  endtask

  task automatic test_abort();
    obs_t e;
    int   strobes = 0;
    logic [AW-1:0] b = AW'($urandom_range(0, 1023));
    run_load(b, 1'b1, 1'b1, 4, -1, N + 5);
    for (int c = 0; c < trace.size(); c++) begin
      e = model(b, 1'b1, 1'b1, 4, c);
      if (trace[c].en_t) strobes++;
      n_cmp++;
      if (trace[c] !== e) begin
        n_bad++; $display("FAIL abort c%0d got %s exp %s", c, fmt(trace[c]), fmt(e));
      end
    end
    n_cmp++;
    if (strobes !== 4) begin
      n_bad++; $display("FAIL abort_strobes got %0d exp 4", strobes);
    end
    // a full load must follow cleanly
    run_load(AW'(16), 1'b1, 1'b0, -1, -1, N + 5);
    for (int c = 0; c < trace.size(); c++) begin
      e = model(AW'(16), 1'b1, 1'b0, -1, c);
      n_cmp++;
      if (trace[c] !== e) begin
        n_bad++; $display("FAIL after_abort c%0d got %s exp %s", c, fmt(trace[c]), fmt(e));
      end
    end
  endtask

  task automatic test_start_while_busy();
    obs_t e;
    int   dones = 0;
    run_load(AW'(16), 1'b0, 1'b0, -1, 3, N + 5);
    for (int c = 0; c < trace.size(); c++) begin
      e = model(AW'(16), 1'b0, 1'b0, -1, c);
      if (trace[c].done) dones++;
      n_cmp++;
      if (trace[c] !== e) begin
        n_bad++; $display("FAIL busy_start c%0d got %s exp %s", c, fmt(trace[c]), fmt(e));
      end
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++; $display("FAIL busy_start_dones got %0d exp 1", dones);
    end
  endtask

  task automatic test_start_abort_idle();
    obs_t o;
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.base_addr = AW'(77);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      o = sample();
      n_cmp++;
      if (o.busy !== 1'b0 || o.en_l !== 1'b0 || o.en_t !== 1'b0) begin
        n_bad++; $display("FAIL start_abort_idle c%0d got %s exp idle", c, fmt(o));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    @(negedge clk);
    bus.start = 1'b1; bus.target_top = 1'b0; bus.swap_after = 1'b1; bus.base_addr = AW'(40);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 o = sample();
    n_cmp++;
    if (o !== '0) begin
      n_bad++; $display("FAIL reset_mid got %s exp all zero", fmt(o));
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = sample();
      n_cmp++;
      if (o !== '0) begin
        n_bad++; $display("FAIL reset_idle c%0d got %s exp all zero", c, fmt(o));
      end
    end
    run_load(AW'(40), 1'b1, 1'b0, -1, -1, N + 5);
    for (int c = 0; c < trace.size(); c++) begin
      e = model(AW'(40), 1'b1, 1'b0, -1, c);
      n_cmp++;
      if (trace[c] !== e) begin
        n_bad++; $display("FAIL after_reset c%0d got %s exp %s", c, fmt(trace[c]), fmt(e));
      end
    end
  endtask

  task automatic test_random();
    obs_t e;
    logic [AW-1:0] b;
    bit top, swp;
    for (int k = 0; k < 6; k++) begin
      b   = AW'($urandom_range(0, 1023));
      top = 1'($urandom_range(0, 1));
      swp = 1'($urandom_range(0, 1));
      run_load(b, top, swp, -1, -1, N + 5);
      for (int c = 0; c < trace.size(); c++) begin
        e = model(b, top, swp, -1, c);
        n_cmp++;
        if (trace[c] !== e) begin
          n_bad++; $display("FAIL random%0d c%0d got %s exp %s", k, c, fmt(trace[c]), fmt(e));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    rst = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.target_top = 1'b0;
    bus.swap_after = 1'b0; bus.base_addr = '0;
    #1 test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_left_basic();
    test_top_swap();
    test_addr_wrap();
    test_abort();
    test_start_while_busy();
    test_start_abort_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Streams one MATRIX_SIZE-element operand vector from the dual-port scratchpad (read port B) into the left or top input buffer of the systolic array.
- Sits between the FSM controller and the systolic array's buffer load interface.
- The controller issues one start per LOAD_LEFT/LOAD_TOP instruction; the block raises done when the vector is loaded, plus the optional buffer swap.

Parameters:
DATA_WIDTH, 8, operand element width
MATRIX_SIZE, 8, elements per vector / buffer depth
DP_ADDR_WIDTH, 10, scratchpad address width
ADDR_WIDTH, $clog2(MATRIX_SIZE), buffer index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle load request; accepted only in IDLE
target_top  in  1  0 = left buffer, 1 = top buffer; sampled with start
swap_after  in  1  pulse buffer swap after load; sampled with start
base_addr  in  DP_ADDR_WIDTH  scratchpad address of element 0; sampled with start
abort  in  1  synchronous cancel
rd_addr  out  DP_ADDR_WIDTH  scratchpad port-B address (registered)
rd_data  in  DATA_WIDTH  scratchpad port-B data; synchronous read, 1-cycle latency
load_en_left / load_en_top  out  1  buffer write strobes
addr_left / addr_top  out  ADDR_WIDTH  buffer element index
data_in_left / data_in_top  out  DATA_WIDTH  buffer write data
swap_buffers_left / swap_buffers_top  out  1  one-cycle swap pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, rd_addr 0, all strobes, busy and done 0.
- States: IDLE, READ, DRAIN, SWAP, DONE.
- IDLE:
  - On start at edge E0: latch target_top, swap_after and base_addr; set rd_addr <= base_addr and issue_cnt <= 1; go to READ.
  - In the same edge, load_cnt <= 0 and rd_valid <= 0.
- READ:
  - Each edge: rd_addr <= rd_addr+1, wrapping modulo 2^DP_ADDR_WIDTH; issue_cnt++.
  - After MATRIX_SIZE addresses have been issued (edges E0..E(N-1)), go to DRAIN.
- Load pipeline:
  - rd_valid is a register set one edge after each address issue.
  - While rd_valid=1, load_en_<target>=1, addr_<target>=load_cnt, data_in_<target>=rd_data (combinational pass-through).
  - load_cnt increments on every such edge.
  - Strobe cycles are the cycles following E1..EN: exactly MATRIX_SIZE contiguous strobes at indices 0..N-1.
- DRAIN: wait until the last strobe (load_cnt = N-1) completes. Then go to SWAP if swap_after is latched, otherwise to DONE.
- SWAP: swap_buffers_<target>=1 for exactly one cycle; go to DONE.
- DONE: done=1 for one cycle; go to IDLE. A new start is accepted on the next edge, which is in IDLE.
- Non-target outputs: held 0 at all times; addr/data of the non-target port are also 0.
- start while busy: ignored, with no latch and no side effect.
- abort:
  - Takes priority over all transitions; at the next edge go to IDLE with all strobes 0.
  - No done and no swap are issued.
  - Buffer elements already written stay written.
- start and abort together in IDLE: abort wins and start is dropped.
- Reset mid-operation: immediate return to reset values; no strobe or swap glitch.
- Latency, start edge to done pulse: N+2 cycles without swap, N+3 with swap (done high in the cycle after edge E(N+1) or E(N+2)).
- Address wrap: base_addr = 2^DP_ADDR_WIDTH - k reads the top k words, then words 0.. onward.

Decomposition:
- Shared vpu package holds:
  - enum loader_state_t {IDLE, READ, DRAIN, SWAP, DONE}.
  - Target encoding constants TGT_LEFT=0 and TGT_TOP=1, reused by the FSM controller's instruction decode.
- No sub-module. Counters and the rd_valid pipeline register are inline.

Test Plan:
- Scratchpad[16..23]=1..8; start, target_top=0, base=16, swap_after=0 → load_en_left for 8 contiguous cycles, addr_left 0..7, data_in_left 1..8; load_en_top never high; done 10 cycles after start edge.
- Same setup with target_top=1, swap_after=1 → top strobes only; swap_buffers_top high for one cycle immediately after the last strobe; done one cycle later (11 cycles total).
- base=1020 → rd_addr sequence 1020,1021,1022,1023,0,1,2,3; data loaded matches those words in that order.
- abort asserted during the 4th strobe → exactly 4 strobes (indices 0..3), no swap, no done; busy low next cycle; a subsequent start runs a full 8-element load.
- start pulsed while busy with base=500 → ignored; the running load completes from its original base; exactly one done pulse.
- rst dropped to 0 mid-READ → all outputs 0 asynchronously; after release, idle until the next start.
